// File: rtl/acos.sv
// BF16 arccosine in whole degrees [0,180]: decode to Q2.14, bit-serial sqrt, then 14-step CORDIC vectoring.
// Latency 32 cycles from accepted start to done (1 on invalid input); start outside IDLE is dropped.
`ifndef INPUTOUTBIT
`define INPUTOUTBIT 16
`endif

module acos (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [`INPUTOUTBIT-1:0] a,
  output logic [`INPUTOUTBIT-1:0] result,
  output logic                    error,
  output logic                    done
);
  localparam int W = `INPUTOUTBIT;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_SQRT   = 3'd2,
    S_VECTOR = 3'd3,
    S_OUTPUT = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, a_d, result_q, result_d;
  logic               error_q, error_d, done_q, done_d, sign_q, sign_d;
  logic [14:0]        q_q, q_d, root_q, root_d;
  logic [29:0]        rad_q, rad_d;
  logic [17:0]        rem_q, rem_d;
  logic signed [17:0] x_q, x_d, y_q, y_d;
  logic signed [15:0] z_q, z_d;
  logic [3:0]         iter_q, iter_d;

  logic [7:0]         in_exp, dec_exp, shamt;
  logic [6:0]         in_man;
  logic               in_err;
  logic [14:0]        q_dec;
  logic [29:0]        q_sq;
  logic [19:0]        rem_sh, trial;
  logic               sq_bit;
  logic signed [17:0] x_sh, y_sh;
  logic signed [15:0] t_val;
  logic signed [16:0] z_rnd, deg_s;
  logic [7:0]         deg, res8;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = in_err ? S_IDLE : S_DECODE;
      S_DECODE: state_d = S_SQRT;
      S_SQRT:   if (iter_q == 4'd14) state_d = S_VECTOR;
      S_VECTOR: if (iter_q == 4'd13) state_d = S_OUTPUT;
      S_OUTPUT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // atan(2^-i) in Q8.8 degrees
  always_comb begin
    case (iter_q)
      4'd0:    t_val = 16'sd11520;
      4'd1:    t_val = 16'sd6801;
      4'd2:    t_val = 16'sd3593;
      4'd3:    t_val = 16'sd1824;
      4'd4:    t_val = 16'sd916;
      4'd5:    t_val = 16'sd458;
      4'd6:    t_val = 16'sd229;
      4'd7:    t_val = 16'sd115;
      4'd8:    t_val = 16'sd57;
      4'd9:    t_val = 16'sd29;
      4'd10:   t_val = 16'sd14;
      4'd11:   t_val = 16'sd7;
      4'd12:   t_val = 16'sd4;
      4'd13:   t_val = 16'sd2;
      default: t_val = 16'sd0;
    endcase
  end

  always_comb begin
    in_exp  = a[14:7];
    in_man  = a[6:0];
    in_err  = (in_exp == 8'hFF) || (in_exp > 8'd127) ||
              ((in_exp == 8'd127) && (in_man != 7'd0));

    dec_exp = a_q[14:7];
    shamt   = 8'd127 - dec_exp;
    if ((dec_exp == 8'd0) || (shamt >= 8'd15)) q_dec = 15'd0;
    else                                        q_dec = {1'b1, a_q[6:0], 7'b0} >> shamt[3:0];
    q_sq    = 30'(q_dec) * 30'(q_dec);

    // Restoring sqrt step: bring down the next two radicand bits
    rem_sh  = {rem_q, rad_q[29:28]};
    trial   = {3'b000, root_q, 2'b01};
    sq_bit  = (rem_sh >= trial);

    x_sh    = x_q >>> iter_q;
    y_sh    = y_q >>> iter_q;

    z_rnd   = {z_q[15], z_q} + 17'sd128;
    deg_s   = z_rnd >>> 8;
    if (deg_s < 17'sd0)       deg = 8'd0;
    else if (deg_s > 17'sd90) deg = 8'd90;
    else                      deg = deg_s[7:0];
    res8    = sign_q ? (8'd180 - deg) : deg;
  end

  always_comb begin
    a_d      = a_q;
    result_d = result_q;
    error_d  = 1'b0;
    done_d   = 1'b0;
    sign_d   = sign_q;
    q_d      = q_q;
    rad_d    = rad_q;
    rem_d    = rem_q;
    root_d   = root_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    iter_d   = iter_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d = a;
          if (in_err) begin
            result_d = {1'b1, {(W-1){1'b0}}};
            error_d  = 1'b1;
            done_d   = 1'b1;
          end
        end
      end
      S_DECODE: begin
        sign_d = a_q[15];
        q_d    = q_dec;
        rad_d  = 30'h1000_0000 - q_sq;
        rem_d  = 18'd0;
        root_d = 15'd0;
        iter_d = 4'd0;
      end
      S_SQRT: begin
        rem_d  = sq_bit ? 18'(rem_sh - trial) : rem_sh[17:0];
        root_d = 15'({root_q, sq_bit});
        rad_d  = {rad_q[27:0], 2'b00};
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd14) begin
          x_d    = {3'b000, q_q};
          y_d    = {3'b000, root_d};
          z_d    = 16'sd0;
          iter_d = 4'd0;
        end
      end
      S_VECTOR: begin
        if (y_q > 18'sd0) begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + t_val;
        end else begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - t_val;
        end
        iter_d = iter_q + 4'd1;
      end
      S_OUTPUT: begin
        result_d = {{(W-8){1'b0}}, res8};
        done_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
      done_q   <= 1'b0;
      sign_q   <= 1'b0;
      q_q      <= '0;
      rad_q    <= '0;
      rem_q    <= '0;
      root_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      iter_q   <= '0;
    end else begin
      a_q      <= a_d;
      result_q <= result_d;
      error_q  <= error_d;
      done_q   <= done_d;
      sign_q   <= sign_d;
      q_q      <= q_d;
      rad_q    <= rad_d;
      rem_q    <= rem_d;
      root_q   <= root_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      iter_q   <= iter_d;
    end
  end

  assign result = result_q;
  assign error  = error_q;
  assign done   = done_q;

endmodule

// File: tb/tb_acos.sv
// Directed bench for acos: expected result/error/latency queued at issue, checked when done arrives.
module tb_acos;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = 16'h0000;
  logic [15:0] result;
  logic        error;
  logic        done;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int done_cnt = 0;
  int start_cyc = 0;
  int snap = 0;

  typedef struct {
    logic [15:0] res;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  acos dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .result (result),
    .error  (error),
    .done   (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [15:0] res, input logic err);
    exp_t e;
    e.res = res;
    e.err = err;
    e.lat = err ? 1 : 32;
    sb.push_back(e);
  endtask

  // Called #1 after an edge; start is sampled at the next edge.
  task automatic issue(input logic [15:0] v);
    a = v;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    e = sb.pop_front();
    check({tag, "_done_seen"}, {15'd0, done}, 16'd1);
    check({tag, "_result"}, result, e.res);
    check({tag, "_error"}, {15'd0, error}, {15'd0, e.err});
    check({tag, "_latency"}, 16'(cyc - start_cyc + 1), 16'(e.lat));
  endtask

  task automatic run(input string tag, input logic [15:0] v, input logic [15:0] res, input logic err);
    push(res, err);
    issue(v);
    wait_done(tag);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {15'd0, done}, 16'd0);
    check({tag, "_error_pulse"}, {15'd0, error}, 16'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", result, 16'h0000);
    check("reset_done", {15'd0, done}, 16'd0);
    check("reset_error", {15'd0, error}, 16'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run("one",      16'h3F80, 16'd0,   1'b0);
    run("neg_one",  16'hBF80, 16'd180, 1'b0);
    run("half",     16'h3F00, 16'd60,  1'b0);
    run("neg_half", 16'hBF00, 16'd120, 1'b0);
    run("rt_half",  16'h3F35, 16'd45,  1'b0);
    run("pos_zero", 16'h0000, 16'd90,  1'b0);
    run("neg_zero", 16'h8000, 16'd90,  1'b0);
    run("subnorm",  16'h0001, 16'd90,  1'b0);
    run("two",      16'h4000, 16'h8000, 1'b1);
    run("gt_one",   16'h3F81, 16'h8000, 1'b1);
    run("nan",      16'h7FC0, 16'h8000, 1'b1);
    run("inf",      16'h7F80, 16'h8000, 1'b1);

    // Second start while busy must be dropped; a start in the done cycle is accepted.
    snap = done_cnt;
    push(16'd60, 1'b0);
    issue(16'h3F00);
    repeat (4) @(posedge clk);
    #1;
    a = 16'h3F80;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("busy");
    push(16'd120, 1'b0);
    issue(16'hBF00);
    wait_done("b2b");
    repeat (40) @(posedge clk);
    #1;
    check("busy_done_count", 16'(done_cnt - snap), 16'd2);

    // Reset during SQRT aborts the operation without a done.
    issue(16'h3F00);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_result", result, 16'h0000);
    check("midrst_done", {15'd0, done}, 16'd0);
    check("midrst_error", {15'd0, error}, 16'd0);
    rst = 1'b0;
    snap = done_cnt;
    repeat (40) @(posedge clk);
    #1;
    check("midrst_no_done", 16'(done_cnt - snap), 16'd0);
    run("after_rst", 16'h3F00, 16'd60, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
